// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_if
// Brief    : Requester handshake and RAM control bundle for ram_port_arbiter.
// Revision : 1.0
// ============================================================================
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  req0;
    logic                  wr0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  gnt0;
    logic                  done0;

    logic                  req1;
    logic                  wr1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt1;
    logic                  done1;

    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;
    logic                  ram_we;
    logic                  ram_en;
    logic [ADDR_WIDTH-1:0] ram_addr;

    // Arbiter side
    modport slave (
        input  req0, wr0, addr0, wdata0,
        input  req1, wr1, addr1, wdata1,
        output gnt0, done0, gnt1, done1,
        output rdata, busy, ram_we, ram_en, ram_addr
    );

    // Client / RAM side
    modport master (
        output req0, wr0, addr0, wdata0,
        output req1, wr1, addr1, wdata1,
        input  gnt0, done0, gnt1, done1,
        input  rdata, busy, ram_we, ram_en, ram_addr
    );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Two-port round-robin arbiter/sequencer for a single-port async RAM.
// Revision : 1.0
// ============================================================================
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  wire                   clk,
    input  wire                   rst_n,
    ram_port_arbiter_if.slave     bus,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]            state;
    logic [1:0]            next_state;

    logic                  owner;
    logic                  last_owner;
    logic                  acc_wr;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  drive;

    logic                  arb_start;
    logic                  arb_win;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  gnt0_d;
    logic                  gnt1_d;
    logic                  done0_d;
    logic                  done1_d;
    logic                  busy_d;
    logic                  we_d;
    logic                  en_d;
    logic                  drive_d;
    logic [ADDR_WIDTH-1:0] addr_d;

    // Port 1 wins only when alone, or on a tie when port 0 owned the last access
    assign arb_start = (state == S_IDLE) && (bus.req0 || bus.req1);
    assign arb_win   = bus.req1 && (!bus.req0 || !last_owner);
    assign sel_wr    = arb_win ? bus.wr1    : bus.wr0;
    assign sel_addr  = arb_win ? bus.addr1  : bus.addr0;
    assign sel_wdata = arb_win ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (arb_start) next_state = S_SETUP;
            S_SETUP:  next_state = S_ACCESS;
            S_ACCESS: next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Decode the value each registered output takes in the upcoming state
    always_comb begin
        gnt0_d  = arb_start && !arb_win;
        gnt1_d  = arb_start &&  arb_win;
        we_d    = (state == S_SETUP) &&  acc_wr;
        en_d    = (state == S_SETUP) && !acc_wr;
        drive_d = (state == S_SETUP) &&  acc_wr;
        done0_d = (state == S_ACCESS) && !owner;
        done1_d = (state == S_ACCESS) &&  owner;
        busy_d  = (next_state != S_IDLE);
        addr_d  = arb_start ? sel_addr : bus.ram_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.gnt0     <= 1'b0;
            bus.gnt1     <= 1'b0;
            bus.done0    <= 1'b0;
            bus.done1    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.ram_we   <= 1'b0;
            bus.ram_en   <= 1'b0;
            bus.ram_addr <= '0;
            bus.rdata    <= '0;
            drive        <= 1'b0;
            owner        <= 1'b0;
            last_owner   <= 1'b1;
            acc_wr       <= 1'b0;
            acc_addr     <= '0;
            acc_wdata    <= '0;
        end else begin
            bus.gnt0     <= gnt0_d;
            bus.gnt1     <= gnt1_d;
            bus.done0    <= done0_d;
            bus.done1    <= done1_d;
            bus.busy     <= busy_d;
            bus.ram_we   <= we_d;
            bus.ram_en   <= en_d;
            bus.ram_addr <= addr_d;
            drive        <= drive_d;
            if (arb_start) begin
                owner      <= arb_win;
                last_owner <= arb_win;
                acc_wr     <= sel_wr;
                acc_addr   <= sel_addr;
                acc_wdata  <= sel_wdata;
            end
            // The RAM drives the bus for the whole read ACCESS cycle
            if (state == S_ACCESS && !acc_wr) begin
                bus.rdata <= ram_data;
            end
        end
    end

    assign ram_data = drive ? acc_wdata : {DATA_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Self-checking bench for ram_port_arbiter with an async RAM model.
// Revision : 1.0
// ============================================================================
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    wire  [7:0] ram_data;

    ram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_data (ram_data)
    );

    always #5 clk = ~clk;

    logic [7:0] ram_mem [8];
    logic [7:0] ref_mem [8];
    logic       model_last;
    logic [7:0] exp_rdata;
    int         checks = 0;
    int         errors = 0;

    // Asynchronous RAM: reads combinationally while enabled, writes mid-cycle
    assign ram_data = (bus.ram_en && !bus.ram_we) ? ram_mem[bus.ram_addr] : 8'bz;
    always @(negedge clk) if (bus.ram_we) ram_mem[bus.ram_addr] <= ram_data;

    always @(negedge clk) begin
        checks++;
        if (bus.ram_we && bus.ram_en) begin
            errors++; $display("FAIL we_en_overlap: got we=%b en=%b, required not both 1", bus.ram_we, bus.ram_en);
        end
        checks++;
        if (!bus.ram_we && !bus.ram_en && $countones(ram_data) != 0) begin
            errors++; $display("FAIL bus_release: got ram_data=%h, required Z", ram_data);
        end
        checks++;
        if ((bus.gnt0 && bus.gnt1) || (bus.done0 && bus.done1)) begin
            errors++; $display("FAIL both_ports: got gnt=%b%b done=%b%b, required exclusive", bus.gnt1, bus.gnt0, bus.done1, bus.done0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 3'd1;
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 3'd2;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.ram_we, bus.ram_en} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b, required 0000000",
                {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.ram_we, bus.ram_en});
        end
        checks++;
        if (bus.ram_addr !== 3'd0 || bus.rdata !== 8'd0 || $countones(ram_data) != 0) begin
            errors++; $display("FAIL reset_data: got addr=%h rdata=%h bus=%h, required 0 0 Z", bus.ram_addr, bus.rdata, ram_data);
        end
        rst_n = 1'b1;
        model_last = 1'b1;
        exp_rdata  = 8'd0;
        tick();
        checks++;
        if ({bus.gnt1, bus.gnt0} !== 2'b01 || bus.busy !== 1'b1 || bus.ram_addr !== 3'd1) begin
            errors++; $display("FAIL reset_first_grant: got gnt=%b%b busy=%b addr=%h, required 01 1 1",
                bus.gnt1, bus.gnt0, bus.busy, bus.ram_addr);
        end
        model_last = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        tick();
        exp_rdata = ref_mem[1];
        checks++;
        if (bus.done0 !== 1'b1 || bus.rdata !== exp_rdata) begin
            errors++; $display("FAIL reset_first_done: got done0=%b rdata=%h, required 1 %h", bus.done0, bus.rdata, exp_rdata);
        end
        tick();
    endtask

    task automatic test_write_read();
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 3'd3; bus.wdata0 = 8'hA5;
        tick();
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.ram_addr !== 3'd3 || bus.ram_we !== 1'b0 || bus.ram_en !== 1'b0) begin
            errors++; $display("FAIL wr_setup: got gnt0=%b addr=%h we=%b en=%b, required 1 3 0 0",
                bus.gnt0, bus.ram_addr, bus.ram_we, bus.ram_en);
        end
        model_last = 1'b0;
        bus.req0 = 1'b0; bus.wdata0 = 8'h00; bus.addr0 = 3'd0;
        tick();
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_en !== 1'b0 || ram_data !== 8'hA5 || bus.ram_addr !== 3'd3) begin
            errors++; $display("FAIL wr_access: got we=%b en=%b data=%h addr=%h, required 1 0 a5 3",
                bus.ram_we, bus.ram_en, ram_data, bus.ram_addr);
        end
        tick();
        ref_mem[3] = 8'hA5;
        checks++;
        if (bus.done0 !== 1'b1 || bus.ram_we !== 1'b0 || bus.rdata !== exp_rdata) begin
            errors++; $display("FAIL wr_done: got done0=%b we=%b rdata=%h, required 1 0 %h", bus.done0, bus.ram_we, bus.rdata, exp_rdata);
        end
        tick();
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 3'd3;
        tick();
        checks++;
        if (bus.gnt0 !== 1'b1) begin
            errors++; $display("FAIL rd_setup: got gnt0=%b, required 1", bus.gnt0);
        end
        bus.req0 = 1'b0;
        tick();
        checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0) begin
            errors++; $display("FAIL rd_access: got en=%b we=%b, required 1 0", bus.ram_en, bus.ram_we);
        end
        tick();
        exp_rdata = ref_mem[3];
        checks++;
        if (bus.done0 !== 1'b1 || bus.ram_en !== 1'b0 || bus.rdata !== exp_rdata) begin
            errors++; $display("FAIL rd_done: got done0=%b en=%b rdata=%h, required 1 0 %h", bus.done0, bus.ram_en, bus.rdata, exp_rdata);
        end
        tick();
    endtask

    task automatic test_fill();
        for (int pass = 0; pass < 2; pass++) begin
            for (int l = 0; l < 8; l++) begin
                bus.req1 = 1'b1; bus.wr1 = (pass == 0); bus.addr1 = 3'(l); bus.wdata1 = 8'(l);
                tick();
                checks++;
                if (bus.gnt1 !== 1'b1 || bus.busy !== 1'b1) begin
                    errors++; $display("FAIL fill_gnt: got gnt1=%b busy=%b at l=%0d, required 1 1", bus.gnt1, bus.busy, l);
                end
                model_last = 1'b1;
                bus.req1 = 1'b0;
                tick();
                checks++;
                if (bus.ram_we !== (pass == 0) || bus.ram_en !== (pass == 1) || bus.busy !== 1'b1) begin
                    errors++; $display("FAIL fill_access: got we=%b en=%b busy=%b at l=%0d", bus.ram_we, bus.ram_en, bus.busy, l);
                end
                tick();
                if (pass == 0) ref_mem[l] = 8'(l);
                else exp_rdata = ref_mem[l];
                checks++;
                if (bus.done1 !== 1'b1 || bus.busy !== 1'b1 || bus.rdata !== exp_rdata) begin
                    errors++; $display("FAIL fill_done: got done1=%b busy=%b rdata=%h at l=%0d, required 1 1 %h",
                        bus.done1, bus.busy, bus.rdata, l, exp_rdata);
                end
                tick();
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++; $display("FAIL fill_idle: got busy=%b at l=%0d, required 0", bus.busy, l);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [2:0] ca [2];
        logic [1:0] exp_g;
        logic [1:0] exp_d;
        int         cur = 0;
        ca[0] = 3'($urandom_range(0, 7));
        ca[1] = 3'($urandom_range(0, 7));
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = ca[0];
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = ca[1];
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k % 4 == 1) begin
                cur = model_last ? 0 : 1;
                model_last = (cur == 1);
            end
            exp_g = (k % 4 == 1) ? ((cur == 1) ? 2'b10 : 2'b01) : 2'b00;
            exp_d = (k % 4 == 3) ? ((cur == 1) ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if ({bus.gnt1, bus.gnt0} !== exp_g || {bus.done1, bus.done0} !== exp_d) begin
                errors++; $display("FAIL contention: cycle %0d got gnt=%b%b done=%b%b, required gnt=%b done=%b",
                    k, bus.gnt1, bus.gnt0, bus.done1, bus.done0, exp_g, exp_d);
            end
            if (k % 4 == 3) begin
                exp_rdata = ref_mem[ca[cur]];
                checks++;
                if (bus.rdata !== exp_rdata) begin
                    errors++; $display("FAIL contention_rdata: got %h, required %h", bus.rdata, exp_rdata);
                end
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            int         p;
            int         n;
            int         ord [2];
            logic       w [2];
            logic [2:0] a [2];
            logic [7:0] d [2];
            p = $urandom_range(1, 3);
            for (int i = 0; i < 2; i++) begin
                w[i] = 1'($urandom_range(0, 1));
                a[i] = 3'($urandom_range(0, 7));
                d[i] = 8'($urandom_range(1, 255));
            end
            bus.req0 = (p != 2); bus.wr0 = w[0]; bus.addr0 = a[0]; bus.wdata0 = d[0];
            bus.req1 = (p != 1); bus.wr1 = w[1]; bus.addr1 = a[1]; bus.wdata1 = d[1];
            if (p == 3) begin
                ord[0] = model_last ? 0 : 1; ord[1] = 1 - ord[0]; n = 2;
            end else begin
                ord[0] = (p == 1) ? 0 : 1; ord[1] = 0; n = 1;
            end
            for (int j = 0; j < n; j++) begin
                int o;
                o = ord[j];
                model_last = (o == 1);
                tick();
                checks++;
                if ({bus.gnt1, bus.gnt0} !== ((o == 1) ? 2'b10 : 2'b01) || bus.ram_addr !== a[o]) begin
                    errors++; $display("FAIL rnd_gnt: round %0d got gnt=%b%b addr=%h, required port %0d addr %h",
                        r, bus.gnt1, bus.gnt0, bus.ram_addr, o, a[o]);
                end
                if (o == 0) begin
                    bus.req0 = 1'b0; bus.wr0 = 1'($urandom); bus.addr0 = 3'($urandom); bus.wdata0 = 8'($urandom);
                end else begin
                    bus.req1 = 1'b0; bus.wr1 = 1'($urandom); bus.addr1 = 3'($urandom); bus.wdata1 = 8'($urandom);
                end
                tick();
                checks++;
                if (bus.ram_we !== w[o] || bus.ram_en !== !w[o] || bus.ram_addr !== a[o] || (w[o] && ram_data !== d[o])) begin
                    errors++; $display("FAIL rnd_access: round %0d got we=%b en=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                        r, bus.ram_we, bus.ram_en, bus.ram_addr, ram_data, w[o], a[o], d[o]);
                end
                tick();
                if (w[o]) ref_mem[a[o]] = d[o];
                else exp_rdata = ref_mem[a[o]];
                checks++;
                if ({bus.done1, bus.done0} !== ((o == 1) ? 2'b10 : 2'b01) || bus.rdata !== exp_rdata) begin
                    errors++; $display("FAIL rnd_done: round %0d got done=%b%b rdata=%h, required port %0d rdata %h",
                        r, bus.done1, bus.done0, bus.rdata, o, exp_rdata);
                end
                tick();
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++; $display("FAIL rnd_idle: round %0d got busy=%b, required 0", r, bus.busy);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 3'd5; bus.wdata0 = 8'h3C;
        tick();
        bus.req0 = 1'b0;
        tick();
        checks++;
        if (bus.ram_we !== 1'b1 || ram_data !== 8'h3C) begin
            errors++; $display("FAIL midrst_access: got we=%b data=%h, required 1 3c", bus.ram_we, ram_data);
        end
        rst_n = 1'b0;
        #1;
        model_last = 1'b1;
        exp_rdata  = 8'd0;
        checks++;
        if (bus.ram_we !== 1'b0 || bus.busy !== 1'b0 || $countones(ram_data) != 0 || bus.rdata !== exp_rdata) begin
            errors++; $display("FAIL midrst_async: got we=%b busy=%b data=%h rdata=%h, required 0 0 Z 00",
                bus.ram_we, bus.busy, ram_data, bus.rdata);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (bus.done0 !== 1'b0 || bus.gnt0 !== 1'b0) begin
                errors++; $display("FAIL midrst_no_done: got done0=%b gnt0=%b, required 0 0", bus.done0, bus.gnt0);
            end
        end
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 3'd5;
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 3'd2;
        tick();
        checks++;
        if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
            errors++; $display("FAIL midrst_regrant: got gnt=%b%b, required 01", bus.gnt1, bus.gnt0);
        end
        model_last = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        tick();
        exp_rdata = ref_mem[5];
        checks++;
        if (bus.done0 !== 1'b1 || bus.rdata !== exp_rdata) begin
            errors++; $display("FAIL midrst_read: got done0=%b rdata=%h, required 1 %h", bus.done0, bus.rdata, exp_rdata);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        model_last = 1'b1;
        exp_rdata  = 8'd0;
        for (int i = 0; i < 8; i++) begin
            ram_mem[i] = 8'd0;
            ref_mem[i] = 8'd0;
        end
        test_reset();
        test_write_read();
        test_fill();
        test_contention();
        test_random();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single-port asynchronous RAM (we, enable, addr, inout data).
- Accepts one access at a time from either requester port and drives the RAM control strobes and address.
- Owns the tri-state drive of the shared data bus and returns read data with a done pulse.
- Sits between client logic (DMA, CPU-side) and the RAM instance. It is the only driver of RAM controls.

Parameters:
DATA_WIDTH, 8, RAM word width
ADDR_WIDTH, 3, RAM address width (depth 2**ADDR_WIDTH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 access request
wr0  in  1  requester 0: 1=write, 0=read
addr0  in  ADDR_WIDTH  requester 0 address
wdata0  in  DATA_WIDTH  requester 0 write data
gnt0  out  1  one-cycle pulse: requester 0 request captured
done0  out  1  one-cycle pulse: requester 0 access complete
req1, wr1, addr1, wdata1, gnt1, done1  same as port 0, for requester 1
rdata  out  DATA_WIDTH  read data, valid while doneN=1 after a read
busy  out  1  1 when FSM is not IDLE
ram_we  out  1  to RAM we
ram_en  out  1  to RAM enable
ram_addr  out  ADDR_WIDTH  to RAM addr
ram_data  inout  DATA_WIDTH  RAM data bus

Behaviour:
- Reset (asynchronous, rst_n=0): FSM=IDLE, ram_we=0, ram_en=0, ram_addr=0, ram_data=Z, gnt0/1=0, done0/1=0, rdata=0, busy=0, last_owner=1 (port 0 wins first tie).
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- IDLE, on clock edge with any req:
  - Single req: that port wins.
  - Both req: the port not equal to last_owner wins; last_owner is then set to the winner.
  - Latch owner, wr, addr and wdata; go to SETUP.
  - No req: stay in IDLE.
- SETUP (1 cycle): ram_addr=latched addr; ram_we=0, ram_en=0; gnt[owner]=1; busy=1. Next state: ACCESS.
- ACCESS (1 cycle), write: ram_we=1, ram_en=0, ram_data driven with latched wdata. Read: ram_we=0, ram_en=1, ram_data=Z. Address is held. At the end of a read ACCESS cycle, rdata captures ram_data. Next state: DONE.
- DONE (1 cycle): ram_we=0, ram_en=0, ram_data=Z; done[owner]=1; busy=1. rdata holds the captured value, or its previous value after a write. Next state: IDLE.
- ram_data is driven only in the write ACCESS cycle; Z in every other state. ram_we and ram_en are never 1 together.
- Access cost: 4 cycles including the IDLE arbitration edge. Back-to-back requests are served every 4 cycles.
- Requester protocol:
  - Hold req, wr, addr and wdata stable until gnt is seen.
  - Drop req the cycle after gnt.
  - A req still high when the FSM returns to IDLE is treated as a new request.
- Requests arriving while busy=1 are ignored until IDLE. There is no queueing.
- rdata persists until the next read completes.
- Reset asserted mid-access: immediate return to reset values, bus released, no done pulse, and the pending access is lost. The RAM contents are not the arbiter's concern.
- gnt and done never assert for both ports in the same cycle.

Test Plan:
- Reset: hold rst_n=0 with req0=req1=1 -> all outputs at reset values, ram_data=Z, no gnt. Release -> port 0 granted first.
- Single write then read: port 0 writes addr 3, data 8'hA5 -> gnt0 in SETUP, ram_we=1 for exactly one cycle with ram_data=A5 and ram_addr=3, done0 next cycle. Port 0 reads addr 3 -> ram_en=1 for one cycle, done0 with rdata=A5.
- Fill and check: port 1 writes addr l with data l for l=0..7, then reads back all 8 -> rdata equals l at each done1. Each access spans 4 cycles; busy is low only in IDLE.
- Contention fairness: req0 and req1 held high continuously, both reads -> grants alternate 0,1,0,1 starting with 0. gnt and done are never simultaneous across ports.
- Bus ownership: monitor every cycle -> ram_data is non-Z only when ram_we=1. (ram_we && ram_en) never occurs.
- Reset mid-write: assert rst_n=0 during ACCESS of a write to addr 5 -> ram_we drops asynchronously, bus goes Z, no done0. After release, the FSM is in IDLE and accepts new requests normally.
